// File: rtl/port_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter_pkg
// Shared types and constants for the per-port round-robin scheduler.
//   pkt_t      32-bit packet word; the low bits carry the destination port id
//   NUM_PORTS  number of router ports (default requester count)
//   rr_next    wrap-around successor of a requester index
// -----------------------------------------------------------------------------
package port_rr_arbiter_pkg;

  localparam int NUM_PORTS = 4;
  localparam int PKT_W     = 32;
  localparam int DEST_W    = $clog2(NUM_PORTS);

  typedef struct packed {
    logic [PKT_W-DEST_W-1:0] payload;
    logic [DEST_W-1:0]       dest_id;
  } pkt_t;

  // Index that follows idx in a ring of n requesters.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/port_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter_if
// Bundles the requester side and the output-stage side of one port scheduler.
//   req_valid  requester i has a packet for this port
//   req_pkt    packet offered by requester i
//   req_accept one-hot (or zero) consume strobe back to the requesters
//   out_pkt    registered winning packet
//   out_valid  out_pkt holds a packet
//   out_ready  downstream FIFO can take a packet
//   starve     requester i has waited STARVE_LIMIT cycles
// master = arbiter side, slave = requesters / downstream side.
// -----------------------------------------------------------------------------
import port_rr_arbiter_pkg::*;

interface port_rr_arbiter_if #(
  parameter int NREQ = NUM_PORTS
) ();

  logic [NREQ-1:0] req_valid;
  pkt_t [NREQ-1:0] req_pkt;
  logic [NREQ-1:0] req_accept;
  pkt_t            out_pkt;
  logic            out_valid;
  logic            out_ready;
  logic [NREQ-1:0] starve;

  modport master (
    input  req_valid,
    input  req_pkt,
    input  out_ready,
    output req_accept,
    output out_pkt,
    output out_valid,
    output starve
  );

  modport slave (
    output req_valid,
    output req_pkt,
    output out_ready,
    input  req_accept,
    input  out_pkt,
    input  out_valid,
    input  starve
  );

endinterface

// File: rtl/port_rr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter_rr_pick
// Combinational rotating-priority picker. Searches i_req starting at i_ptr,
// then i_ptr+1, ... wrapping modulo N, and returns the first set bit.
//   i_req     request vector
//   i_ptr     index holding highest priority
//   o_onehot  one-hot of the chosen index (zero when no request)
//   o_idx     binary index of the chosen request
//   o_any     at least one request is set
// -----------------------------------------------------------------------------
module port_rr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int w_pos;

  // Walk offsets from farthest to nearest so the nearest hit overwrites.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_pos    = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % N;
      if (i_req[w_pos]) begin
        o_onehot        = '0;
        o_onehot[w_pos] = 1'b1;
        o_idx           = IW'(w_pos);
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/port_rr_arbiter.sv
// -----------------------------------------------------------------------------
// port_rr_arbiter
// Per-output-port scheduler. Picks one of NREQ requesters round-robin, with a
// starvation override, and registers the winner into a one-deep output stage
// that drains into the port's out_buffer under valid/ready.
//   clk      clock
//   rst_b    synchronous, active-high reset
//   port_if  requester / output-stage bundle (master side)
// Latency: accept in cycle N -> out_valid/out_pkt in cycle N+1.
// -----------------------------------------------------------------------------
import port_rr_arbiter_pkg::*;

module port_rr_arbiter #(
  parameter int NREQ         = NUM_PORTS,
  parameter int STARVE_LIMIT = 15,
  parameter int CW           = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_b,
  port_rr_arbiter_if.master    port_if
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Output stage and round-robin pointer
  pkt_t            r_out_pkt;
  logic            r_out_valid;
  logic [IW-1:0]   r_rr_ptr;

  // Arbitration wires
  logic            w_load_ok;
  logic [NREQ-1:0] w_starve;
  logic [NREQ-1:0] w_starve_req;
  logic [NREQ-1:0] w_rr_onehot;
  logic [IW-1:0]   w_rr_idx;
  logic            w_rr_any;
  logic [NREQ-1:0] w_sv_onehot;
  logic [IW-1:0]   w_sv_idx;
  logic            w_sv_any;
  logic            w_grant_en;
  logic [IW-1:0]   w_win_idx;
  logic [NREQ-1:0] w_win_onehot;
  logic [NREQ-1:0] w_accept;

  // The stage can take a new packet when empty or when its content leaves
  // this same cycle.
  assign w_load_ok    = !r_out_valid || port_if.out_ready;
  assign w_starve_req = w_starve & port_if.req_valid;

  // Plain round-robin among all valid requesters.
  port_rr_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_rr_pick (
    .i_req    (port_if.req_valid),
    .i_ptr    (r_rr_ptr),
    .o_onehot (w_rr_onehot),
    .o_idx    (w_rr_idx),
    .o_any    (w_rr_any)
  );

  // Starved requesters only, fixed lowest-index priority (ptr tied to 0).
  port_rr_arbiter_rr_pick #(.N(NREQ), .IW(IW)) u_sv_pick (
    .i_req    (w_starve_req),
    .i_ptr    ('0),
    .o_onehot (w_sv_onehot),
    .o_idx    (w_sv_idx),
    .o_any    (w_sv_any)
  );

  // Reset forces accept low so no requester drops a packet while the stage
  // is being cleared.
  assign w_grant_en   = w_load_ok && w_rr_any && !rst_b;
  assign w_win_idx    = w_sv_any ? w_sv_idx    : w_rr_idx;
  assign w_win_onehot = w_sv_any ? w_sv_onehot : w_rr_onehot;
  assign w_accept     = w_grant_en ? w_win_onehot : '0;

  // Output stage and pointer
  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_out_pkt   <= '0;
      r_out_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_grant_en) begin
        r_out_pkt   <= port_if.req_pkt[w_win_idx];
        r_out_valid <= 1'b1;
        // Starvation wins also advance the pointer, so the round-robin
        // order resumes just past whoever was served.
        r_rr_ptr    <= IW'(rr_next(int'(w_win_idx), NREQ));
      end else if (r_out_valid && port_if.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Per-requester wait counters. A counter runs while its request is pending
  // and unserved, including while the output stage is stalled.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_wait
      logic [CW-1:0] r_cnt;

      always_ff @(posedge clk) begin
        if (rst_b) begin
          r_cnt <= '0;
        end else if (!port_if.req_valid[gi] || w_accept[gi]) begin
          r_cnt <= '0;
        end else if (r_cnt != CW'(STARVE_LIMIT)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_starve[gi] = (r_cnt == CW'(STARVE_LIMIT));
    end
  endgenerate

  assign port_if.req_accept = w_accept;
  assign port_if.out_pkt    = r_out_pkt;
  assign port_if.out_valid  = r_out_valid;
  assign port_if.starve     = w_starve;

endmodule
